// File: rtl/karatsuba_mult_seq.sv
// karatsuba_mult_seq: handshaked sequential Karatsuba multiplier sharing one
// (DATA_W/2+1)-bit multiplier across three partial products, then a registered combine.
module karatsuba_mult_seq #(
   parameter int DATA_W    = 32,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     A,
   input  logic [DATA_W-1:0]     B,
   input  logic                  signed_mode,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [2*DATA_W-1:0]   S,
   output logic                  busy
);
   localparam int H = DATA_W / 2;

   typedef enum logic [2:0] {IDLE, P_HIGH, P_LOW, P_MID, COMBINE, DONE} state_t;

   state_t              state, state_nx;
   logic [DATA_W-1:0]   a_mag, b_mag, m1, m2, a_abs, b_abs;
   logic [DATA_W+1:0]   m3, mid, prod;
   logic [H:0]          a_hi, a_lo, b_hi, b_lo, mul_x, mul_y;
   logic [2*DATA_W-1:0] p;
   logic                neg, s_en;

   assign s_en  = SIGNED_EN & signed_mode;
   assign a_abs = (s_en && A[DATA_W-1]) ? -A : A;
   assign b_abs = (s_en && B[DATA_W-1]) ? -B : B;

   assign a_hi = {1'b0, a_mag[DATA_W-1:H]};
   assign a_lo = {1'b0, a_mag[H-1:0]};
   assign b_hi = {1'b0, b_mag[DATA_W-1:H]};
   assign b_lo = {1'b0, b_mag[H-1:0]};

   // The single shared multiplier; operand pair chosen by the current phase.
   assign mul_x = (state == P_HIGH) ? a_hi : (state == P_LOW) ? a_lo : a_hi + a_lo;
   assign mul_y = (state == P_HIGH) ? b_hi : (state == P_LOW) ? b_lo : b_hi + b_lo;
   assign prod  = {{(H+1){1'b0}}, mul_x} * {{(H+1){1'b0}}, mul_y};

   // m1 and m2 never overlap once shifted, so they simply concatenate.
   assign mid = m3 - {2'b00, m1} - {2'b00, m2};
   assign p   = {m1, m2} + ({{(DATA_W-2){1'b0}}, mid} << H);

   always_comb begin
      state_nx  = state;
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      busy      = (state != IDLE);
      case (state)
         IDLE:    if (in_valid) state_nx = P_HIGH;
         P_HIGH:  state_nx = P_LOW;
         P_LOW:   state_nx = P_MID;
         P_MID:   state_nx = COMBINE;
         COMBINE: state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         a_mag <= '0;
         b_mag <= '0;
         neg   <= 1'b0;
         m1    <= '0;
         m2    <= '0;
         m3    <= '0;
         S     <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && in_valid) begin
            a_mag <= a_abs;
            b_mag <= b_abs;
            neg   <= s_en & (A[DATA_W-1] ^ B[DATA_W-1]);
         end
         if (state == P_HIGH) m1 <= prod[DATA_W-1:0];
         if (state == P_LOW) m2 <= prod[DATA_W-1:0];
         if (state == P_MID) m3 <= prod;
         if (state == COMBINE) S <= neg ? -p : p;
      end
   end
endmodule

// File: tb/tb_karatsuba_mult_seq.sv
// tb_karatsuba_mult_seq: directed checks on a 32-bit instance, then randomized
// traffic on 8/16/32/64-bit instances against a plain-arithmetic product model.
module tb_karatsuba_mult_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic         in_valid[4], in_ready[4], sm[4], out_valid[4], out_ready[4], busy[4];
   logic [63:0]  a[4], b[4];
   logic [127:0] s[4];

   int n_cmp = 0;
   int n_bad = 0;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int W = 8 << g;
      logic [2*W-1:0] s_w;
      karatsuba_mult_seq #(.DATA_W(W), .SIGNED_EN(1'b1)) dut (
         .clk(clk), .rst_n(rst_n), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
         .A(a[g][W-1:0]), .B(b[g][W-1:0]), .signed_mode(sm[g]),
         .out_valid(out_valid[g]), .out_ready(out_ready[g]), .S(s_w), .busy(busy[g]));
      assign s[g] = 128'(s_w);
   end

   function automatic logic [127:0] ref_mul(input int w, input logic [63:0] x, input logic [63:0] y, input logic sg);
      logic [127:0] xe, ye, m;
      m  = (128'd1 << w) - 128'd1;
      xe = {64'd0, x} & m;
      ye = {64'd0, y} & m;
      if (sg && xe[w-1]) xe = xe - (128'd1 << w);
      if (sg && ye[w-1]) ye = ye - (128'd1 << w);
      return (xe * ye) & ((128'd1 << (2 * w)) - 128'd1);
   endfunction

   function automatic logic [63:0] pick(input int w);
      int r;
      r = $urandom_range(0, 7);
      if (r == 0) return 64'd0;
      if (r == 1) return '1;
      if (r == 2) return 64'd1 << (w - 1);
      return {$urandom, $urandom};
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accepts one operand pair on the 32-bit instance and follows it to DONE.
   task automatic xact(input logic [31:0] x, input logic [31:0] y, input logic sg,
                       input logic [63:0] exp, input string tag);
      int t;
      t = 0;
      while (!in_ready[2] && t < 50) begin
         tick();
         t++;
      end
      check({tag, " ready"}, in_ready[2], 1);
      a[2] = {32'd0, x};
      b[2] = {32'd0, y};
      sm[2] = sg;
      in_valid[2] = 1'b1;
      tick();
      in_valid[2] = 1'b0;
      a[2] = {$urandom, $urandom};
      b[2] = {$urandom, $urandom};
      sm[2] = 1'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++) begin
         check({tag, " in_ready low"}, in_ready[2], 0);
         check({tag, " early out_valid"}, out_valid[2], 0);
         tick();
      end
      check({tag, " out_valid"}, out_valid[2], 1);
      check({tag, " busy"}, busy[2], 1);
      check({tag, " S"}, s[2], {64'd0, exp});
   endtask

   task automatic drain(input string tag);
      out_ready[2] = 1'b1;
      tick();
      out_ready[2] = 1'b0;
      check({tag, " drained"}, out_valid[2], 0);
      check({tag, " idle ready"}, in_ready[2], 1);
   endtask

   localparam int NR = 2500;
   logic [127:0] q[4][$];
   int  issued[4], got[4];
   bit  acc[4];
   bit  done;
   int  cyc;
   logic [63:0] held;

   initial begin
      for (int k = 0; k < 4; k++) begin
         in_valid[k] = 1'b0;
         out_ready[k] = 1'b0;
         sm[k] = 1'b0;
         a[k] = '0;
         b[k] = '0;
         issued[k] = 0;
         got[k] = 0;
      end
      repeat (3) tick();
      check("rst in_ready", in_ready[2], 1);
      check("rst out_valid", out_valid[2], 0);
      check("rst busy", busy[2], 0);
      check("rst S", s[2], 0);
      rst_n = 1'b1;
      tick();
      check("post-rst in_ready", in_ready[2], 1);

      xact(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, "max_u");
      drain("max_u");
      xact(32'hFFFFFFFD, 32'h00000005, 1'b1, 64'hFFFFFFFFFFFFFFF1, "neg3x5");
      drain("neg3x5");
      xact(32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, "minneg_s");
      drain("minneg_s");
      xact(32'h80000000, 32'h80000000, 1'b0, 64'h4000000000000000, "minneg_u");
      drain("minneg_u");
      xact(32'h0001FFFF, 32'h0001FFFF, 1'b0, 64'h00000003FFFC0001, "carry");
      drain("carry");
      xact(32'h00000000, 32'hFFFFFFFF, 1'b0, 64'h0, "zero");
      drain("zero");

      xact(32'h12345678, 32'h9ABCDEF0, 1'b0, 64'h0B00EA4E242D2080, "bp");
      for (int i = 0; i < 10; i++) begin
         in_valid[2] = 1'(i & 1);
         a[2] = {$urandom, $urandom};
         tick();
         check("bp out_valid", out_valid[2], 1);
         check("bp in_ready", in_ready[2], 0);
         check("bp S stable", s[2], 128'h0B00EA4E242D2080);
      end
      in_valid[2] = 1'b0;
      drain("bp");
      for (int i = 0; i < 6; i++) begin
         tick();
         check("bp single handshake", out_valid[2], 0);
      end

      a[2] = 64'hFFFFFFFF;
      b[2] = 64'hFFFFFFFF;
      sm[2] = 1'b0;
      in_valid[2] = 1'b1;
      tick();
      in_valid[2] = 1'b0;
      tick();
      tick();
      check("mid busy", busy[2], 1);
      rst_n = 1'b0;
      #1;
      check("async rst in_ready", in_ready[2], 1);
      check("async rst out_valid", out_valid[2], 0);
      check("async rst busy", busy[2], 0);
      check("async rst S", s[2], 0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("no result after rst", out_valid[2], 0);
      end
      xact(32'd7, 32'd6, 1'b0, 64'd42, "7x6");
      drain("7x6");

      done = 1'b0;
      cyc = 0;
      while (!done && cyc < 60000) begin
         for (int k = 0; k < 4; k++) begin
            if (out_valid[k] && out_ready[k]) begin
               if (q[k].size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $error("FAIL rnd%0d spurious result: observed %h expected none", k, s[k]);
               end else begin
                  held = 64'(k);
                  check($sformatf("rnd%0d S #%0d", k, got[k]), s[k], q[k].pop_front());
                  got[k]++;
               end
            end
            acc[k] = in_valid[k] && in_ready[k];
            if (acc[k]) begin
               q[k].push_back(ref_mul(8 << k, a[k], b[k], sm[k]));
               issued[k]++;
            end
         end
         tick();
         cyc++;
         done = 1'b1;
         for (int k = 0; k < 4; k++) begin
            if (acc[k]) in_valid[k] = 1'b0;
            if (!in_valid[k] && issued[k] < NR && $urandom_range(0, 3) != 0) begin
               a[k] = pick(8 << k);
               b[k] = pick(8 << k);
               sm[k] = 1'($urandom_range(0, 1));
               in_valid[k] = 1'b1;
            end
            out_ready[k] = ($urandom_range(0, 3) != 0);
            if (issued[k] < NR || q[k].size() != 0) done = 1'b0;
         end
      end
      check("rnd completed", 1'(done), 1);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("rnd%0d results", k), got[k], NR);
         check($sformatf("rnd%0d leftover", k), q[k].size(), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/karatsuba_mult_seq.md
# karatsuba_mult_seq

Sequential, handshaked Karatsuba multiplier and the parametrised successor to the team's combinational Karatsuba stage. One shared (DATA_W/2+1)-bit multiplier computes the three partial products over three cycles, and a registered combine step follows. Operands are unsigned or two's-complement, selected per transaction. The block sits between operand producers and accumulators in the QFT datapath, where area matters more than throughput.

## Interface
Parameters:
- DATA_W, 32, operand width; even, ≥ 4.
- SIGNED_EN, 1, when 0 the signed_mode input is ignored and treated as 0.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous assert, active-low reset; one clock, reset is asynchronous and active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- A  in  DATA_W  multiplicand.
- B  in  DATA_W  multiplier.
- signed_mode  in  1  1 = A and B are two's complement; sampled with the operands.
- out_valid  out  1  S holds a result.
- out_ready  in  1  consumer accepts S.
- S  out  2*DATA_W  product; unsigned, or two's complement in signed mode.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE → P_HIGH → P_LOW → P_MID → COMBINE → DONE → IDLE.
- IDLE: in_ready = 1. When in_valid & in_ready, register the operands, then go to P_HIGH:
  - s = SIGNED_EN & signed_mode.
  - If s is set, register |A| and |B| as DATA_W-bit unsigned values, and register neg = A[msb]^B[msb].
  - If s is clear, register A and B unchanged and set neg = 0.
  - The most negative operand, 2^(DATA_W-1), has a magnitude that fits in DATA_W bits.
- Each magnitude splits into a high half and a low half of DATA_W/2 bits: Ah, Al, Bh, Bl.
- P_HIGH: m1 ← Ah*Bh (DATA_W bits).
- P_LOW: m2 ← Al*Bl (DATA_W bits).
- P_MID: m3 ← (Ah+Al)*(Bh+Bl).
  - Both sums are DATA_W/2+1 bits; m3 is DATA_W+2 bits.
  - The same multiplier instance is used in P_HIGH, P_LOW and P_MID; halves are zero-extended to DATA_W/2+1 bits.
- COMBINE:
  - mid = m3 − m1 − m2. mid is non-negative and at most DATA_W+1 bits; compute it at DATA_W+2 bits, and no borrow may escape.
  - p = (m1 << DATA_W) + (mid << DATA_W/2) + m2, computed modulo 2^(2*DATA_W).
  - S ← neg ? (~p + 1) : p.
- DONE: out_valid = 1 and S is held stable. On out_ready, go to IDLE.
- in_ready is 0 in every state except IDLE. No new operand is accepted while a result is pending.
- A, B and signed_mode are don't-care outside the accepting cycle.

## Timing
- Reset (rst_n low, asynchronous): state = IDLE, in_ready = 1, out_valid = 0, busy = 0, S = 0, and all internal registers = 0.
  - Reset mid-transaction discards the operation; no result is produced.
  - In the cycle after rst_n deasserts, in_ready = 1.
- Latency: operands are accepted at edge E0. m1, m2 and m3 are registered at E1, E2 and E3; S is registered at E4. out_valid is high from E4 onward.
- Output handshake completes at the first edge where out_valid & out_ready. IDLE follows in the next cycle, with in_ready = 1.
- Throughput with out_ready held high: one result every 6 cycles (IDLE accept, 4 compute cycles, DONE).
- Backpressure: with out_ready low, the block stays in DONE indefinitely, and S and out_valid stay constant.
- in_valid asserted while busy is ignored; the producer must hold it until in_ready.
- out_valid never asserts without a prior accept, and is never deasserted before the output handshake.

## Test plan
- Unsigned, DATA_W=32, A=B=0xFFFFFFFF → S=0xFFFFFFFE00000001, out_valid at E4 after accept, in_ready low during E0–E4.
- Signed, A=0xFFFFFFFD (−3), B=0x00000005 → S=0xFFFFFFFFFFFFFFF1. Also A=B=0x80000000 signed → S=0x4000000000000000, and the same pair unsigned → S=0x4000000000000000.
- Carry paths, unsigned: A=0x0001FFFF, B=0x0001FFFF → S=0x00000003FFFC0001. A=0, B=0xFFFFFFFF → S=0.
- Backpressure: hold out_ready low for 10 cycles after out_valid → S is stable, in_ready stays 0, and in_valid pulses are ignored. Then raise out_ready → exactly one output handshake, and in_ready = 1 in the next cycle.
- Reset mid-operation: assert rst_n low in state P_MID → all outputs return to reset values immediately and no out_valid appears. A following transaction of 7*6 → S=42.
- Random: 10k transactions with random DATA_W∈{8,16,32,64}, random signed_mode and random handshake stalls, checked against a behavioural multiply. Verify result order and that no transaction is lost or duplicated.
